// File: rtl/mod_updown_counter.sv
// Modulo up/down counter with load, wrap/saturate boundary handling,
// per-direction terminal-count pulses and a sticky overflow flag.
// The counter value always stays within 0..MAX_COUNT.
module mod_updown_counter #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       up_dwn,
    input  logic             sat,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             up_tc,
    output logic             dn_tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    logic [WIDTH-1:0] count_reg, count_next;
    logic             up_tc_reg, up_tc_next;
    logic             dn_tc_reg, dn_tc_next;
    logic             ovf_reg,   ovf_next;

    // Next-state: operation decode, boundary detection and sticky flag update.
    always_comb begin
        count_next = count_reg;
        up_tc_next = 1'b0;
        dn_tc_next = 1'b0;
        ovf_next   = ovf_reg;

        if (en) begin
            case (up_dwn)
                OP_UP: begin
                    if (count_reg == MAX_VAL) begin
                        // Up-boundary: wrap to zero or pin at the top.
                        up_tc_next = 1'b1;
                        count_next = sat ? MAX_VAL : '0;
                    end else begin
                        count_next = count_reg + 1'b1;
                    end
                end
                OP_DOWN: begin
                    if (count_reg == '0) begin
                        // Down-boundary: wrap to the top or pin at zero.
                        dn_tc_next = 1'b1;
                        count_next = sat ? '0 : MAX_VAL;
                    end else begin
                        count_next = count_reg - 1'b1;
                    end
                end
                OP_LOAD: begin
                    // Out-of-range load values clamp so count never leaves 0..MAX.
                    count_next = (load_val > MAX_VAL) ? MAX_VAL : load_val;
                end
                OP_HOLD: begin
                    count_next = count_reg;
                end
                default: begin
                    count_next = count_reg;
                end
            endcase
        end

        // Clear works regardless of en; a same-cycle boundary event overrides it.
        if (ovf_clr) begin
            ovf_next = 1'b0;
        end
        if (up_tc_next || dn_tc_next) begin
            ovf_next = 1'b1;
        end
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
            up_tc_reg <= 1'b0;
            dn_tc_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            up_tc_reg <= up_tc_next;
            dn_tc_reg <= dn_tc_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign count = count_reg;
    assign up_tc = up_tc_reg;
    assign dn_tc = dn_tc_reg;
    assign ovf   = ovf_reg;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench for mod_updown_counter (WIDTH=4, MAX_COUNT=9):
// directed scenarios followed by random traffic, all compared against an
// integer-arithmetic reference model of the counter's rules.
module tb_mod_updown_counter;

    localparam int W    = 4;
    localparam int MAXC = 9;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic [1:0]   up_dwn;
    logic         sat;
    logic [W-1:0] load_val;
    logic         ovf_clr;
    logic [W-1:0] count;
    logic         up_tc;
    logic         dn_tc;
    logic         ovf;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state (plain integers / bits).
    int m_count = 0;
    bit m_up    = 1'b0;
    bit m_dn    = 1'b0;
    bit m_ovf   = 1'b0;

    mod_updown_counter #(
        .WIDTH     (W),
        .MAX_COUNT (MAXC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up_dwn   (up_dwn),
        .sat      (sat),
        .load_val (load_val),
        .ovf_clr  (ovf_clr),
        .count    (count),
        .up_tc    (up_tc),
        .dn_tc    (dn_tc),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model, then compare all outputs.
    task automatic step(input bit r, input bit e, input int op, input bit s,
                        input int lv, input bit clr, input string tag);
        @(negedge clk);
        reset    = r;
        en       = e;
        up_dwn   = 2'(op);
        sat      = s;
        load_val = W'(lv);
        ovf_clr  = clr;
        @(posedge clk);
        if (r) begin
            m_count = 0;
            m_up    = 1'b0;
            m_dn    = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            m_up = 1'b0;
            m_dn = 1'b0;
            if (e) begin
                if (op == 1) begin
                    if (m_count == MAXC) begin
                        m_up    = 1'b1;
                        m_count = s ? MAXC : 0;
                    end else begin
                        m_count = m_count + 1;
                    end
                end else if (op == 2) begin
                    if (m_count == 0) begin
                        m_dn    = 1'b1;
                        m_count = s ? 0 : MAXC;
                    end else begin
                        m_count = m_count - 1;
                    end
                end else if (op == 3) begin
                    m_count = (lv > MAXC) ? MAXC : lv;
                end
            end
            if (m_up || m_dn) m_ovf = 1'b1;
            else if (clr)     m_ovf = 1'b0;
        end
        #1;
        $display("%-10s rst=%0d en=%0d op=%0d sat=%0d lv=%0d clr=%0d -> count=%0d up_tc=%0d dn_tc=%0d ovf=%0d",
                 tag, r, e, op, s, lv, clr, count, up_tc, dn_tc, ovf);
        chk({tag, ".count"}, 16'(count), 16'(m_count));
        chk({tag, ".up_tc"}, 16'(up_tc), 16'(m_up));
        chk({tag, ".dn_tc"}, 16'(dn_tc), 16'(m_dn));
        chk({tag, ".ovf"},   16'(ovf),   16'(m_ovf));
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; up_dwn = 2'b00; sat = 1'b0; load_val = '0; ovf_clr = 1'b0;

        // Reset state.
        step(1, 0, 0, 0, 0, 0, "reset");
        step(1, 1, 1, 0, 0, 0, "reset");

        // Up-count wrap: 1..9 then 0 with up_tc and ovf.
        for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 0, 0, "up_wrap");
        chk("up_wrap.final", 16'(count), 16'd0);

        // Down-count wrap from 0: 9 with dn_tc, then 8.
        step(0, 1, 2, 0, 0, 0, "dn_wrap");
        chk("dn_wrap.nine", 16'(count), 16'd9);
        step(0, 1, 2, 0, 0, 0, "dn_wrap");

        // Saturate at the top: repeated up_tc pulses, then step down.
        step(0, 1, 3, 0, 9, 0, "load9");
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0, 0, "sat_up");
        step(0, 1, 2, 1, 0, 0, "sat_dn");

        // Saturate at the bottom.
        step(0, 1, 3, 0, 0, 0, "load0");
        for (int i = 0; i < 2; i++) step(0, 1, 2, 1, 0, 0, "sat_dn0");

        // Load clamp and enable gating.
        step(0, 1, 3, 0, 13, 0, "clamp");
        chk("clamp.value", 16'(count), 16'd9);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0, "en_off");

        // Sticky priority: set beats clear, then clear with hold.
        step(0, 1, 1, 0, 0, 1, "set_win");
        chk("set_win.ovf", 16'(ovf), 16'd1);
        step(0, 1, 0, 0, 0, 1, "clr_hold");
        chk("clr_hold.ovf", 16'(ovf), 16'd0);

        // Clear with en=0.
        step(0, 1, 2, 0, 0, 0, "dn_evt");
        step(0, 0, 2, 0, 0, 1, "clr_en0");

        // Reset in the middle of a counting run.
        step(0, 1, 3, 0, 0, 0, "load0");
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, 0, "run");
        chk("run.five", 16'(count), 16'd5);
        step(1, 1, 1, 0, 0, 1, "mid_rst");
        step(0, 1, 1, 0, 0, 0, "post_rst");
        chk("post_rst.one", 16'(count), 16'd1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 7) != 0),
                 int'($urandom_range(0, 3)),
                 bit'($urandom_range(0, 1)),
                 int'($urandom_range(0, 15)),
                 ($urandom_range(0, 7) == 0),
                 "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
